// File: rtl/palindrome_checker_seq_if.sv
// palindrome_checker_seq_if
//   Request/result bundle for palindrome_checker_seq.
//   Optional feature macro: PALINDROME_COUNT_EN (adds digit_count).
//
//   start          requester -> checker  request, sampled while busy=0
//   number         requester -> checker  unsigned operand, sampled on accept
//   busy           checker -> requester  operation in progress
//   done           checker -> requester  one-cycle result-valid pulse
//   is_palindrome  checker -> requester  result, held until next done
//   digit_count    checker -> requester  operand digit count (PALINDROME_COUNT_EN only)
interface palindrome_checker_seq_if #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             start;
  logic [WIDTH-1:0] number;
  logic             busy;
  logic             done;
  logic             is_palindrome;

  // CW must be able to hold the largest digit count (WIDTH, for binary).
  generate
    if ((1 << CW) <= WIDTH) begin : g_bad_cw
      $error("CW too narrow for WIDTH");
    end
  endgenerate

`ifdef PALINDROME_COUNT_EN
  logic [CW-1:0] digit_count;

  modport master (output start, number, input busy, done, is_palindrome, digit_count);
  modport slave  (input start, number, output busy, done, is_palindrome, digit_count);
`else
  modport master (output start, number, input busy, done, is_palindrome);
  modport slave  (input start, number, output busy, done, is_palindrome);
`endif
endinterface

// File: rtl/palindrome_checker_seq.sv
// palindrome_checker_seq
//   Multi-cycle palindrome detector. The operand is reversed one RADIX digit
//   per clock; when the remaining operand reaches zero the reversed value is
//   compared with the original over the full reversal width, and a done pulse
//   reports the result.
//   Optional feature macro: PALINDROME_COUNT_EN (digit count output + counter).
//
//   Parameters: WIDTH (operand bits, >= 2), RADIX (2..16), CW (derived).
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  palindrome_checker_seq_if.slave (start/number in; busy/done/
//          is_palindrome[/digit_count] out, all registered)
module palindrome_checker_seq #(
  parameter int WIDTH = 16,
  parameter int RADIX = 10,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  palindrome_checker_seq_if.slave  bus
);

  // rev < RADIX * 2^WIDTH <= 2^(WIDTH+4), so four extra bits never truncate.
  localparam int REV_W = WIDTH + 4;
  localparam logic [REV_W-1:0] RADIX_R = REV_W'(RADIX);

  generate
    if (RADIX < 2 || RADIX > 16) begin : g_bad_radix
      $error("RADIX must be in the range 2..16");
    end
    if (WIDTH < 2) begin : g_bad_width
      $error("WIDTH must be at least 2");
    end
    if ((1 << CW) <= WIDTH) begin : g_bad_cw
      $error("CW too narrow for WIDTH");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   orig_reg, orig_next;
  logic [WIDTH-1:0]   work_reg, work_next;
  logic [REV_W-1:0]   rev_reg, rev_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               pal_reg, pal_next;

  // One reversal step, computed at REV_W bits so RADIX=16 stays representable
  // even for very narrow operands.
  logic [REV_W-1:0]   work_ext;
  logic [REV_W-1:0]   step_digit;
  logic [REV_W-1:0]   step_rev;
  logic [WIDTH-1:0]   step_work;

`ifdef PALINDROME_COUNT_EN
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [CW-1:0]      count_reg, count_next;
`endif

  always_comb begin
    work_ext   = REV_W'(work_reg);
    step_digit = work_ext % RADIX_R;
    step_rev   = rev_reg * RADIX_R + step_digit;
    step_work  = WIDTH'(work_ext / RADIX_R);
  end

  always_comb begin
    state_next = state_reg;
    orig_next  = orig_reg;
    work_next  = work_reg;
    rev_next   = rev_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    pal_next   = pal_reg;
`ifdef PALINDROME_COUNT_EN
    cnt_next   = cnt_reg;
    count_next = count_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          orig_next  = bus.number;
          work_next  = bus.number;
          rev_next   = '0;
`ifdef PALINDROME_COUNT_EN
          cnt_next   = '0;
`endif
          busy_next  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        rev_next  = step_rev;
        work_next = step_work;
`ifdef PALINDROME_COUNT_EN
        cnt_next  = cnt_reg + CW'(1);
`endif
        // A zero operand still takes one step and reverses to 0, so it is
        // reported as the one-digit palindrome "0".
        if (step_work == '0) begin
          pal_next   = (step_rev == REV_W'(orig_reg));
`ifdef PALINDROME_COUNT_EN
          count_next = cnt_reg + CW'(1);
`endif
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      orig_reg  <= '0;
      work_reg  <= '0;
      rev_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      pal_reg   <= 1'b0;
`ifdef PALINDROME_COUNT_EN
      cnt_reg   <= '0;
      count_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      orig_reg  <= orig_next;
      work_reg  <= work_next;
      rev_reg   <= rev_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      pal_reg   <= pal_next;
`ifdef PALINDROME_COUNT_EN
      cnt_reg   <= cnt_next;
      count_reg <= count_next;
`endif
    end
  end

  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;
  assign bus.is_palindrome = pal_reg;
`ifdef PALINDROME_COUNT_EN
  assign bus.digit_count   = count_reg;
`endif

endmodule

// File: tb/tb_palindrome_checker_seq.sv
// tb_palindrome_checker_seq
//   Scoreboard bench for palindrome_checker_seq with three instances:
//   decimal 16-bit, binary 8-bit and hexadecimal 16-bit. Stimulus pushes the
//   hand-computed result (palindrome flag, digit count = busy cycles) into a
//   per-instance queue; monitors pop and compare on every done pulse.
module tb_palindrome_checker_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  palindrome_checker_seq_if #(.WIDTH(16)) dec_if ();
  palindrome_checker_seq_if #(.WIDTH(8))  bin_if ();
  palindrome_checker_seq_if #(.WIDTH(16)) hex_if ();

  palindrome_checker_seq #(.WIDTH(16), .RADIX(10)) u_dec (.clk(clk), .rst(rst), .bus(dec_if));
  palindrome_checker_seq #(.WIDTH(8),  .RADIX(2))  u_bin (.clk(clk), .rst(rst), .bus(bin_if));
  palindrome_checker_seq #(.WIDTH(16), .RADIX(16)) u_hex (.clk(clk), .rst(rst), .bus(hex_if));

  typedef struct {
    string tag;
    int    pal;
    int    cnt;
  } exp_t;

  exp_t q_dec[$];
  exp_t q_bin[$];
  exp_t q_hex[$];

  int total = 0;
  int bad   = 0;
  int lat_dec = 0;
  int lat_bin = 0;
  int lat_hex = 0;

  logic [7:0] dc_dec, dc_bin, dc_hex;
`ifdef PALINDROME_COUNT_EN
  assign dc_dec = 8'(dec_if.digit_count);
  assign dc_bin = 8'(bin_if.digit_count);
  assign dc_hex = 8'(hex_if.digit_count);
`else
  assign dc_dec = 8'd0;
  assign dc_bin = 8'd0;
  assign dc_hex = 8'd0;
`endif

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_done(input string inst, input exp_t e, input int pal,
                            input int busy, input int dc, input int lat);
    $display("%s %s: is_palindrome=%0d digit_count=%0d busy_cycles=%0d",
             inst, e.tag, pal, dc, lat);
    chk({inst, "_", e.tag, "_pal"}, pal, e.pal);
    chk({inst, "_", e.tag, "_latency"}, lat, e.cnt);
    chk({inst, "_", e.tag, "_busy_at_done"}, busy, 0);
`ifdef PALINDROME_COUNT_EN
    chk({inst, "_", e.tag, "_digit_count"}, dc, e.cnt);
`endif
  endtask

  // Monitors: busy cycles since the previous done give the latency.
  always @(negedge clk) begin
    if (rst) lat_dec = 0;
    else if (dec_if.done) begin
      if (q_dec.size() == 0) chk("dec_spurious_done", 1, 0);
      else check_done("dec", q_dec.pop_front(), int'(dec_if.is_palindrome),
                      int'(dec_if.busy), int'(dc_dec), lat_dec);
      lat_dec = 0;
    end else if (dec_if.busy) lat_dec++;
  end

  always @(negedge clk) begin
    if (rst) lat_bin = 0;
    else if (bin_if.done) begin
      if (q_bin.size() == 0) chk("bin_spurious_done", 1, 0);
      else check_done("bin", q_bin.pop_front(), int'(bin_if.is_palindrome),
                      int'(bin_if.busy), int'(dc_bin), lat_bin);
      lat_bin = 0;
    end else if (bin_if.busy) lat_bin++;
  end

  always @(negedge clk) begin
    if (rst) lat_hex = 0;
    else if (hex_if.done) begin
      if (q_hex.size() == 0) chk("hex_spurious_done", 1, 0);
      else check_done("hex", q_hex.pop_front(), int'(hex_if.is_palindrome),
                      int'(hex_if.busy), int'(dc_hex), lat_hex);
      lat_hex = 0;
    end else if (hex_if.busy) lat_hex++;
  end

  task automatic drive(input int which, input logic s, input int num);
    case (which)
      0: begin dec_if.start = s; dec_if.number = 16'(num); end
      1: begin bin_if.start = s; bin_if.number = 8'(num);  end
      default: begin hex_if.start = s; hex_if.number = 16'(num); end
    endcase
  endtask

  task automatic push(input int which, input string tag, input int pal, input int cnt);
    exp_t e;
    e.tag = tag;
    e.pal = pal;
    e.cnt = cnt;
    case (which)
      0: q_dec.push_back(e);
      1: q_bin.push_back(e);
      default: q_hex.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int which);
    case (which)
      0: return q_dec.size();
      1: return q_bin.size();
      default: return q_hex.size();
    endcase
  endfunction

  task automatic issue(input int which, input string tag, input int num,
                       input int pal, input int cnt);
    @(negedge clk);
    drive(which, 1'b1, num);
    push(which, tag, pal, cnt);
    @(posedge clk);
    #1;
    drive(which, 1'b0, num);
  endtask

  // Wait (bounded) until every expected result has been reported.
  task automatic drain(input int which);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (qsize(which) == 0) break;
    end
    if (qsize(which) != 0) begin
      chk("drain_timeout", qsize(which), 0);
      case (which)
        0: q_dec.delete();
        1: q_bin.delete();
        default: q_hex.delete();
      endcase
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    drive(2, 1'b0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dec_busy", int'(dec_if.busy), 0);
    chk("rst_dec_done", int'(dec_if.done), 0);
    chk("rst_dec_pal", int'(dec_if.is_palindrome), 0);
    chk("rst_bin_busy", int'(bin_if.busy), 0);
    chk("rst_hex_done", int'(hex_if.done), 0);
`ifdef PALINDROME_COUNT_EN
    chk("rst_dec_digit_count", int'(dc_dec), 0);
`endif
    rst = 1'b0;

    // Decimal, 16-bit
    issue(0, "12321", 12321, 1, 5); drain(0);
    issue(0, "12345", 12345, 0, 5); drain(0);
    issue(0, "65519", 65519, 0, 5); drain(0);
    issue(0, "zero",  0,     1, 1); drain(0);

    // Binary, 8-bit
    issue(1, "A5", 8'hA5, 1, 8); drain(1);
    issue(1, "06", 8'h06, 0, 3); drain(1);

    // Hexadecimal, 16-bit
    issue(2, "ABBA", 16'hABBA, 1, 4); drain(2);
    issue(2, "1234", 16'h1234, 0, 4); drain(2);

    // start while busy is ignored; start held through done is accepted there
    issue(0, "12321_busy", 12321, 1, 5);      // accept edge E0 passed
    @(posedge clk);                           // E1
    @(negedge clk);
    drive(0, 1'b1, 55);                       // sampled at E2, busy
    @(posedge clk);
    #1;
    drive(0, 1'b0, 55);
    @(posedge clk);                           // E3
    @(negedge clk);
    drive(0, 1'b1, 121);                      // held until accepted after done
    push(0, "121_b2b", 1, 3);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (dec_if.done) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) chk("b2b_done_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    drive(0, 1'b0, 121);
    drain(0);

    // Reset in the middle of RUN: no done for the aborted operation
    @(negedge clk);
    drive(0, 1'b1, 12321);
    @(posedge clk);                           // E0
    #1;
    drive(0, 1'b0, 12321);
    repeat (2) @(posedge clk);                // E1, E2
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_rst_busy", int'(dec_if.busy), 0);
    chk("midrun_rst_done", int'(dec_if.done), 0);
    chk("midrun_rst_pal", int'(dec_if.is_palindrome), 0);
`ifdef PALINDROME_COUNT_EN
    chk("midrun_rst_digit_count", int'(dc_dec), 0);
`endif
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(0, "7_after_rst", 7, 1, 1); drain(0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
